// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: merges the ALU writeback and the load-return stream onto the single
// register-file write port. ALU writes take priority and never stall. Loads wait in a
// small FIFO and drain on idle ALU cycles. An ALU write cancels any older queued load
// to the same register (WAW), so the stale load data never reaches the RF.
// Optional feature macro: WB_BYPASS_EN (forwarding search over the queued loads).
module rf_wb_arbiter #(
    parameter int unsigned AW     = 5,
    parameter int unsigned DW     = 32,
    parameter int unsigned QDEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alu_we,
    input  logic [AW-1:0]             alu_addr,
    input  logic [DW-1:0]             alu_data,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [AW-1:0]             ld_addr,
    input  logic [DW-1:0]             ld_data,
    output logic                      rf_we,
    output logic [AW-1:0]             rf_addr,
    output logic [DW-1:0]             rf_data,
    output logic [$clog2(QDEPTH):0]   q_count,
    input  logic [AW-1:0]             byp_addr,
    output logic                      byp_hit,
    output logic [DW-1:0]             byp_data
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] addr_q [QDEPTH];
    logic [DW-1:0] data_q [QDEPTH];
    logic          live_q [QDEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Full is judged on the current occupancy only, so a same-cycle pop never frees a slot early.
    assign ld_ready = (q_count < CW'(QDEPTH));

    // Push when a load is offered and there is room; pop only on cycles the ALU leaves free.
    always_comb begin
        push = ld_valid && ld_ready;
        pop  = !alu_we && (q_count != '0);
    end

    // Load FIFO storage, WAW cancellation and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                live_q[i] <= 1'b0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            // Cancel older entries first; the slot written below is the younger load and stays live.
            if (alu_we) begin
                for (int unsigned i = 0; i < QDEPTH; i++) begin
                    if (addr_q[i] == alu_addr) begin
                        live_q[i] <= 1'b0;
                    end
                end
            end
            if (push) begin
                addr_q[wr_ptr] <= ld_addr;
                data_q[wr_ptr] <= ld_data;
                live_q[wr_ptr] <= 1'b1;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   q_count <= q_count + CW'(1);
                2'b01:   q_count <= q_count - CW'(1);
                default: q_count <= q_count;
            endcase
        end
    end

    // Registered RF write port: ALU first, then FIFO head, otherwise idle with address/data held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we   <= 1'b0;
            rf_addr <= '0;
            rf_data <= '0;
        end else if (alu_we) begin
            rf_we   <= (alu_addr != '0);
            rf_addr <= alu_addr;
            rf_data <= alu_data;
        end else if (q_count != '0) begin
            rf_we   <= live_q[rd_ptr] && (addr_q[rd_ptr] != '0);
            rf_addr <= addr_q[rd_ptr];
            rf_data <= data_q[rd_ptr];
        end else begin
            rf_we   <= 1'b0;
        end
    end

`ifdef WB_BYPASS_EN
    logic [PW-1:0] byp_idx;

    // Walk oldest to youngest so the last live match (the youngest) wins.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        byp_idx  = '0;
        for (int unsigned i = 0; i < QDEPTH; i++) begin
            byp_idx = rd_ptr + PW'(i);
            if ((CW'(i) < q_count) && live_q[byp_idx] &&
                (addr_q[byp_idx] == byp_addr) && (byp_addr != '0)) begin
                byp_hit  = 1'b1;
                byp_data = data_q[byp_idx];
            end
        end
    end
`else
    logic unused_byp_addr;

    // Bypass search not built; query address is deliberately ignored.
    assign unused_byp_addr = ^byp_addr;
    assign byp_hit         = 1'b0;
    assign byp_data        = '0;
`endif

endmodule
